booth_mult_controller: RTL and testbench
========================================

Name: booth_mult_controller

Overview:
- Sequencing controller for the 16-bit radix-2 Booth sequential multiplier datapath.
- Accepts an operand pair over a valid/ready handshake and holds the operands stable for the datapath.
- Drives the datapath control lines (clear, QR_sel, data_sel) from the Booth bit pair and the count-complete flag.
- Captures the 32-bit product and presents it downstream over a second valid/ready handshake, with a watchdog error path.

Parameters:
WIDTH, 16, operand width; product width is 2*WIDTH
TIMEOUT, 40, max CALC cycles before the watchdog error fires; must be > WIDTH+2

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-low reset
src_valid  input  1  operand pair valid
src_ready  output  1  controller can accept operands
multiplicand_i  input  WIDTH  signed multiplicand
multiplier_i  input  WIDTH  signed multiplier
dest_valid  output  1  product_o/err_o valid
dest_ready  input  1  downstream accepts result
product_o  output  2*WIDTH  registered signed product
err_o  output  1  watchdog fired; product_o invalid
busy_o  output  1  high in LOAD and CALC
abort  input  1  synchronous abort to IDLE
dp_multiplicand  output  WIDTH  held multiplicand to datapath
dp_multiplier  output  WIDTH  held multiplier to datapath
dp_product  input  2*WIDTH  datapath shifted product (combinational)
dp_in  input  2  datapath Booth pair {Q[0], Q-1}
dp_count_comp  input  1  datapath step count reached WIDTH
dp_clear  output  1  synchronous clear of datapath registers
dp_qr_sel  output  1  0 = load operands, 1 = shift path
dp_data_sel  output  2  01 = A+M, 10 = A-M, other = A

Behaviour:
Reset (rst low, async):
- State = IDLE.
- src_ready=0, dest_valid=0, product_o=0, err_o=0.
- dp_multiplicand=0, dp_multiplier=0, watchdog=0.
- dp_clear=1, dp_qr_sel=0, dp_data_sel=00.
- src_ready rises on the first clock after reset release.

States: IDLE, LOAD, CALC, DONE.

IDLE:
- dp_clear=1, src_ready=1.
- On src_valid&&src_ready: latch multiplicand_i/multiplier_i into the dp_* holding registers, then go to LOAD.

LOAD (exactly 1 cycle):
- dp_clear=0, dp_qr_sel=0, dp_data_sel=00, src_ready=0.
- Datapath loads Q=multiplier, A=0, M=multiplicand.
- Watchdog cleared. Go to CALC.

CALC:
- dp_clear=0, dp_qr_sel=1.
- dp_data_sel is a combinational function of dp_in: 01 -> 01 (add), 10 -> 10 (sub), 00/11 -> 00.
- Watchdog increments each cycle.
- If dp_count_comp=1: product_o <= dp_product (same-cycle sample), err_o <= 0, go to DONE.
- Else if watchdog == TIMEOUT-1: err_o <= 1, product_o <= 0, go to DONE.
- dp_count_comp has priority over the watchdog in the same cycle.

DONE:
- dest_valid=1, dp_clear=1, src_ready=0.
- product_o and err_o are held stable while dest_valid && !dest_ready.
- On dest_ready: dest_valid drops next cycle, go to IDLE.
- No new operand is accepted in the DONE cycle itself (no bypass).

Latency and throughput:
- src handshake to dest_valid = 1 (LOAD) + N (CALC cycles until dp_count_comp) + 1 clocks.
- One operation in flight at a time.

Abort:
- abort=1 in any state forces IDLE next cycle.
- dest_valid=0, err_o=0, dp_clear=1.
- abort in IDLE with src_valid is ignored; no capture.

Other rules:
- dp_multiplicand/dp_multiplier change only on an IDLE acceptance.
- busy_o = (state==LOAD || state==CALC).
- dp_in and dp_count_comp are ignored outside CALC.

Test Plan:
- Reset mid-CALC (rst low 1 cycle) -> all outputs at reset values immediately; src_ready=1 one clock after release.
- 3 x 5, dest_ready=1 -> dest_valid with product_o=0x0000000F, err_o=0; busy_o high for LOAD+CALC cycles only.
- -7 (0xFFF9) x 6 -> product_o=0xFFFFFFD6; 0x8000 x 0x8000 -> product_o=0x40000000.
- Backpressure: dest_ready=0 for 10 cycles -> dest_valid, product_o, err_o stable; src_ready=0 throughout; a new src_valid is accepted only after return to IDLE.
- Watchdog: bench model holds dp_count_comp=0 -> after TIMEOUT CALC cycles, dest_valid=1, err_o=1, product_o=0.
- Abort asserted in 5th CALC cycle -> IDLE next clock, dp_clear=1, no dest_valid; next op 2 x -3 -> 0xFFFFFFFA.

Source files
------------

// File: rtl/booth_mult_controller.sv
// Sequencing controller for a radix-2 Booth sequential multiplier datapath.
// Holds operands, steers datapath controls, captures the product, watchdogs the run.
//
// state  | meaning
// IDLE   | datapath held clear, operands accepted on src handshake
// LOAD   | datapath loads Q=multiplier, A=0, M=multiplicand (one cycle)
// CALC   | one Booth add/sub + shift per cycle until count-complete or watchdog
// DONE   | result presented downstream, waiting for dest_ready
module booth_mult_controller #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               src_valid,
  output logic               src_ready,
  input  logic [WIDTH-1:0]   multiplicand_i,
  input  logic [WIDTH-1:0]   multiplier_i,
  output logic               dest_valid,
  input  logic               dest_ready,
  output logic [2*WIDTH-1:0] product_o,
  output logic               err_o,
  output logic               busy_o,
  input  logic               abort,
  output logic [WIDTH-1:0]   dp_multiplicand,
  output logic [WIDTH-1:0]   dp_multiplier,
  input  logic [2*WIDTH-1:0] dp_product,
  input  logic [1:0]         dp_in,
  input  logic               dp_count_comp,
  output logic               dp_clear,
  output logic               dp_qr_sel,
  output logic [1:0]         dp_data_sel
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CALC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_rdy_en;
  logic [WDW-1:0]       r_wdog;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_product;
  logic                 r_err;
  logic                 w_accept;
  logic                 w_wdog_fire;

  // r_rdy_en keeps src_ready low until the first clock after reset release
  assign w_accept    = (r_state == S_IDLE) && r_rdy_en && src_valid && !abort;
  assign w_wdog_fire = (r_wdog == WDW'(TIMEOUT - 1));

  assign dp_multiplicand = r_mcand;
  assign dp_multiplier   = r_mplier;
  assign product_o       = r_product;
  assign err_o           = r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    src_ready   = 1'b0;
    dest_valid  = 1'b0;
    busy_o      = 1'b0;
    dp_clear    = 1'b1;
    dp_qr_sel   = 1'b0;
    dp_data_sel = 2'b00;
    case (r_state)
      S_IDLE: begin
        src_ready = r_rdy_en;
        if (w_accept) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        busy_o      = 1'b1;
        dp_clear    = 1'b0;
        w_state_nxt = S_CALC;
      end
      S_CALC: begin
        busy_o    = 1'b1;
        dp_clear  = 1'b0;
        dp_qr_sel = 1'b1;
        case (dp_in)
          2'b01:   dp_data_sel = 2'b01;
          2'b10:   dp_data_sel = 2'b10;
          default: dp_data_sel = 2'b00;
        endcase
        if (dp_count_comp || w_wdog_fire) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        dest_valid = 1'b1;
        if (dest_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (abort) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdy_en  <= 1'b0;
      r_wdog    <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_product <= '0;
      r_err     <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_accept) begin
        r_mcand  <= multiplicand_i;
        r_mplier <= multiplier_i;
      end
      if (r_state == S_LOAD) begin
        r_wdog <= '0;
      end else if (r_state == S_CALC) begin
        r_wdog <= r_wdog + 1'b1;
      end
      // count-complete wins over the watchdog when both land in one cycle
      if (abort) begin
        r_err <= 1'b0;
      end else if (r_state == S_CALC) begin
        if (dp_count_comp) begin
          r_product <= dp_product;
          r_err     <= 1'b0;
        end else if (w_wdog_fire) begin
          r_product <= '0;
          r_err     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_booth_mult_controller.sv
// Directed bench for booth_mult_controller with a behavioural Booth datapath
// attached; expected products and cycle counts are hand-computed.
module tb_booth_mult_controller;

  localparam int W  = 16;
  localparam int TO = 40;

  logic           clk = 1'b0;
  logic           rst;
  logic           src_valid;
  logic           src_ready;
  logic [W-1:0]   multiplicand_i;
  logic [W-1:0]   multiplier_i;
  logic           dest_valid;
  logic           dest_ready;
  logic [2*W-1:0] product_o;
  logic           err_o;
  logic           busy_o;
  logic           abort;
  logic [W-1:0]   dp_multiplicand;
  logic [W-1:0]   dp_multiplier;
  logic [2*W-1:0] dp_product;
  logic [1:0]     dp_in;
  logic           dp_count_comp;
  logic           dp_clear;
  logic           dp_qr_sel;
  logic [1:0]     dp_data_sel;

  int n_cmp = 0;
  int n_err = 0;

  booth_mult_controller #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_ready(src_ready),
    .multiplicand_i(multiplicand_i), .multiplier_i(multiplier_i),
    .dest_valid(dest_valid), .dest_ready(dest_ready),
    .product_o(product_o), .err_o(err_o), .busy_o(busy_o), .abort(abort),
    .dp_multiplicand(dp_multiplicand), .dp_multiplier(dp_multiplier),
    .dp_product(dp_product), .dp_in(dp_in), .dp_count_comp(dp_count_comp),
    .dp_clear(dp_clear), .dp_qr_sel(dp_qr_sel), .dp_data_sel(dp_data_sel)
  );

  always #5 clk = ~clk;

  // Behavioural datapath: A is one bit wider so A-M cannot overflow for 0x8000.
  logic [W:0]   m_a, m_sum, m_a_nxt;
  logic [W-1:0] m_q, m_m, m_q_nxt;
  logic         m_q1;
  logic [7:0]   m_cnt;
  logic         no_comp;

  always_comb begin
    m_sum = m_a;
    case (dp_data_sel)
      2'b01:   m_sum = m_a + {m_m[W-1], m_m};
      2'b10:   m_sum = m_a - {m_m[W-1], m_m};
      default: m_sum = m_a;
    endcase
    m_a_nxt = {m_sum[W], m_sum[W:1]};
    m_q_nxt = {m_sum[0], m_q[W-1:1]};
  end

  assign dp_product    = {m_a_nxt[W-1:0], m_q_nxt};
  assign dp_in         = {m_q[0], m_q1};
  assign dp_count_comp = !no_comp && (m_cnt == 8'(W - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || dp_clear) begin
      m_a <= '0; m_q <= '0; m_m <= '0; m_q1 <= 1'b0; m_cnt <= '0;
    end else if (!dp_qr_sel) begin
      m_a <= '0; m_q <= dp_multiplier; m_m <= dp_multiplicand; m_q1 <= 1'b0; m_cnt <= '0;
    end else begin
      m_a <= m_a_nxt; m_q <= m_q_nxt; m_q1 <= m_q[0]; m_cnt <= m_cnt + 8'd1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int g;
    g = 0;
    while (!src_ready && g < 50) begin
      tick();
      g++;
    end
    chk("src_ready_wait", {63'd0, src_ready}, 64'd1);
    src_valid      = 1'b1;
    multiplicand_i = a;
    multiplier_i   = b;
    tick();
    src_valid = 1'b0;
  endtask

  task automatic wait_done(output int nb);
    int cyc;
    cyc = 0;
    nb  = 0;
    while (!dest_valid && cyc < 200) begin
      if (busy_o) nb++;
      tick();
      cyc++;
    end
    chk("dest_valid_wait", {63'd0, dest_valid}, 64'd1);
  endtask

  initial begin
    int nb;
    int cnt;
    rst = 1'b0; src_valid = 1'b0; multiplicand_i = '0; multiplier_i = '0;
    dest_ready = 1'b1; abort = 1'b0; no_comp = 1'b0;

    // power-on reset
    tick(); tick();
    chk("por_src_ready", {63'd0, src_ready}, 64'd0);
    chk("por_dp_clear", {63'd0, dp_clear}, 64'd1);
    chk("por_product", {32'd0, product_o}, 64'd0);
    rst = 1'b1;
    #1;
    chk("rel_src_ready_low", {63'd0, src_ready}, 64'd0);
    tick();
    chk("rel_src_ready_high", {63'd0, src_ready}, 64'd1);

    // 3 x 5: multiplier 0101 gives pairs 10, 01 in the first two CALC cycles
    start_op(16'd3, 16'd5);
    chk("t1_load_busy", {63'd0, busy_o}, 64'd1);
    chk("t1_load_qr_sel", {63'd0, dp_qr_sel}, 64'd0);
    chk("t1_load_clear", {63'd0, dp_clear}, 64'd0);
    chk("t1_load_src_ready", {63'd0, src_ready}, 64'd0);
    chk("t1_load_mcand", {48'd0, dp_multiplicand}, 64'd3);
    tick();
    chk("t1_calc1_qr_sel", {63'd0, dp_qr_sel}, 64'd1);
    chk("t1_calc1_data_sel", {62'd0, dp_data_sel}, 64'd2);
    tick();
    chk("t1_calc2_data_sel", {62'd0, dp_data_sel}, 64'd1);
    tick();
    wait_done(nb);
    chk("t1_busy_cycles", 64'(nb), 64'd14);
    chk("t1_product", {32'd0, product_o}, 64'h0000000F);
    chk("t1_err", {63'd0, err_o}, 64'd0);
    chk("t1_done_busy", {63'd0, busy_o}, 64'd0);
    chk("t1_done_clear", {63'd0, dp_clear}, 64'd1);
    tick();
    chk("t1_dest_valid_drop", {63'd0, dest_valid}, 64'd0);

    // -7 x 6
    start_op(16'hFFF9, 16'd6);
    wait_done(nb);
    chk("t2_busy_cycles", 64'(nb), 64'd17);
    chk("t2_product", {32'd0, product_o}, 64'hFFFFFFD6);
    chk("t2_err", {63'd0, err_o}, 64'd0);
    tick();

    // 0x8000 x 0x8000
    start_op(16'h8000, 16'h8000);
    wait_done(nb);
    chk("t3_product", {32'd0, product_o}, 64'h40000000);
    tick();

    // backpressure with a new operand pair waiting
    dest_ready = 1'b0;
    start_op(16'h1234, 16'h0010);
    src_valid = 1'b1; multiplicand_i = 16'd7; multiplier_i = 16'd9;
    wait_done(nb);
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold_valid", {63'd0, dest_valid}, 64'd1);
      chk("t4_hold_product", {32'd0, product_o}, 64'h00012340);
      chk("t4_hold_err", {63'd0, err_o}, 64'd0);
      chk("t4_hold_src_ready", {63'd0, src_ready}, 64'd0);
      tick();
    end
    chk("t4_hold_mcand", {48'd0, dp_multiplicand}, 64'h1234);
    dest_ready = 1'b1;
    tick();
    chk("t4_idle_valid", {63'd0, dest_valid}, 64'd0);
    chk("t4_idle_mcand", {48'd0, dp_multiplicand}, 64'h1234);
    tick();
    src_valid = 1'b0;
    chk("t4_next_mcand", {48'd0, dp_multiplicand}, 64'd7);
    chk("t4_next_busy", {63'd0, busy_o}, 64'd1);
    wait_done(nb);
    chk("t4_next_product", {32'd0, product_o}, 64'd63);
    tick();

    // watchdog: datapath never reports count complete
    no_comp = 1'b1;
    start_op(16'd3, 16'd5);
    wait_done(nb);
    chk("t5_busy_cycles", 64'(nb), 64'(TO + 1));
    chk("t5_err", {63'd0, err_o}, 64'd1);
    chk("t5_product", {32'd0, product_o}, 64'd0);
    tick();
    no_comp = 1'b0;

    // abort in the 5th CALC cycle
    start_op(16'd4, 16'd4);
    for (int i = 0; i < 5; i++) tick();
    chk("t6_pre_busy", {63'd0, busy_o}, 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_busy", {63'd0, busy_o}, 64'd0);
    chk("t6_clear", {63'd0, dp_clear}, 64'd1);
    chk("t6_err", {63'd0, err_o}, 64'd0);
    chk("t6_src_ready", {63'd0, src_ready}, 64'd1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (dest_valid) cnt++;
      tick();
    end
    chk("t6_no_dest_valid", 64'(cnt), 64'd0);
    abort = 1'b1; src_valid = 1'b1; multiplicand_i = 16'd9; multiplier_i = 16'd9;
    tick();
    abort = 1'b0; src_valid = 1'b0;
    chk("t6_abort_idle_busy", {63'd0, busy_o}, 64'd0);
    chk("t6_abort_idle_mcand", {48'd0, dp_multiplicand}, 64'd4);
    start_op(16'd2, 16'hFFFD);
    wait_done(nb);
    chk("t6_product", {32'd0, product_o}, 64'hFFFFFFFA);
    tick();

    // reset in the middle of CALC
    start_op(16'd5, 16'd5);
    tick(); tick(); tick();
    rst = 1'b0;
    #1;
    chk("t7_src_ready", {63'd0, src_ready}, 64'd0);
    chk("t7_dest_valid", {63'd0, dest_valid}, 64'd0);
    chk("t7_product", {32'd0, product_o}, 64'd0);
    chk("t7_err", {63'd0, err_o}, 64'd0);
    chk("t7_mcand", {48'd0, dp_multiplicand}, 64'd0);
    chk("t7_mplier", {48'd0, dp_multiplier}, 64'd0);
    chk("t7_clear", {63'd0, dp_clear}, 64'd1);
    chk("t7_qr_sel", {63'd0, dp_qr_sel}, 64'd0);
    chk("t7_data_sel", {62'd0, dp_data_sel}, 64'd0);
    chk("t7_busy", {63'd0, busy_o}, 64'd0);
    tick();
    rst = 1'b1;
    #1;
    chk("t7_rel_src_ready_low", {63'd0, src_ready}, 64'd0);
    tick();
    chk("t7_rel_src_ready_high", {63'd0, src_ready}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1);
  end

endmodule
